// File: rtl/tcb_uart_pkg.sv
// rtl/tcb_uart_pkg.sv - shared TCB PHY type, UART register map and manager FSM states
package tcb_uart_pkg;

  typedef struct packed {
    int unsigned DLY;
  } tcb_phy_t;

  localparam tcb_phy_t TCB_PHY_DEF = '{DLY: 1};

  localparam logic [31:0] ADR_TX_DAT = 32'h00;
  localparam logic [31:0] ADR_TX_BDR = 32'h08;
  localparam logic [31:0] ADR_TX_IRQ = 32'h10;
  localparam logic [31:0] ADR_RX_DAT = 32'h20;
  localparam logic [31:0] ADR_RX_BDR = 32'h28;
  localparam logic [31:0] ADR_RX_SMP = 32'h2C;
  localparam logic [31:0] ADR_RX_IRQ = 32'h30;

  typedef enum logic [2:0] {CFG, IDLE, TXW, RXR, RSP, HOLD} state_t;

endpackage

// File: rtl/tcb_if.sv
// rtl/tcb_if.sv - TCB bus interface; PHY.DLY is the request-to-response latency
interface tcb_if #(
  parameter tcb_uart_pkg::tcb_phy_t PHY = tcb_uart_pkg::TCB_PHY_DEF
) ();

  logic        vld;
  logic        rdy;
  logic        wen;
  logic [31:0] adr;
  logic [3:0]  ben;
  logic [31:0] wdt;
  logic [31:0] rdt;
  logic        sts;

  modport man (output vld, wen, adr, ben, wdt, input rdy, rdt, sts);
  modport sub (input vld, wen, adr, ben, wdt, output rdy, rdt, sts);

endinterface

// File: rtl/tcb_uart_mgr_arb.sv
// rtl/tcb_uart_mgr_arb.sv - 2-way round-robin arbiter between TX and RX accesses
module tcb_uart_mgr_arb (
  input  logic clk,
  input  logic rst,
  input  logic req_tx,
  input  logic req_rx,
  input  logic ack,
  output logic gnt_tx,
  output logic gnt_rx
);

  logic last_rx_q;

  // on a tie the side that was not served last wins
  always_comb begin
    gnt_rx = req_rx && (!req_tx || !last_rx_q);
    gnt_tx = req_tx && !gnt_rx;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      last_rx_q <= 1'b0;
    end else if (ack && (gnt_tx || gnt_rx)) begin
      last_rx_q <= gnt_rx;
    end
  end

endmodule

// File: rtl/tcb_uart_mgr.sv
// rtl/tcb_uart_mgr.sv - TCB manager configuring one UART and moving TX/RX stream bytes
// Optional: TCB_UART_MGR_ERR_EN enables the sticky err flag from response status.
module tcb_uart_mgr
  import tcb_uart_pkg::*;
#(
  parameter int unsigned UDW    = 8,
  parameter int unsigned TX_BDR = 4,
  parameter int unsigned RX_BDR = 4,
  parameter int unsigned RX_SMP = 2,
  parameter int unsigned TX_LVL = 1,
  parameter int unsigned RX_LVL = 0,
  parameter int unsigned HLD    = 2
) (
  input  logic           clk,
  input  logic           rst,
  tcb_if.man             tcb,
  input  logic           tx_vld,
  output logic           tx_rdy,
  input  logic [UDW-1:0] tx_dat,
  output logic           rx_vld,
  input  logic           rx_rdy,
  output logic [UDW-1:0] rx_dat,
  input  logic           irq_tx,
  input  logic           irq_rx,
  output logic           cfg_done,
  output logic           err
);

  localparam int unsigned DLY    = tcb.PHY.DLY;
  localparam logic [7:0]  DLY_M1 = (DLY == 0) ? 8'd0 : 8'(DLY - 1);
  localparam logic [7:0]  HLD_W  = 8'(HLD);

  state_t      state_q, state_d, post_rsp;
  logic [2:0]  idx_q;
  logic [7:0]  dly_q, hold_q;
  logic        vld_q, wen_q;
  logic [31:0] adr_q, wdt_q;
  logic [31:0] cfg_adr, cfg_wdt;
  logic        hs, rsp, req_tx, req_rx, gnt_tx, gnt_rx;
  logic        load_cfg, load_tx, load_rx;

  assign tcb.vld = vld_q;
  assign tcb.wen = wen_q;
  assign tcb.adr = adr_q;
  assign tcb.ben = 4'hF;
  assign tcb.wdt = wdt_q;

  assign hs     = vld_q && tcb.rdy;
  assign rsp    = (DLY == 0) ? hs : (state_q == RSP && dly_q == 8'd0);
  assign tx_rdy = (state_q == TXW) && hs;

  assign req_tx = tx_vld && irq_tx && (hold_q == 8'd0);
  assign req_rx = irq_rx && !rx_vld && (hold_q == 8'd0);

  tcb_uart_mgr_arb u_arb (
    .clk    (clk),
    .rst    (rst),
    .req_tx (req_tx),
    .req_rx (req_rx),
    .ack    (state_q == IDLE),
    .gnt_tx (gnt_tx),
    .gnt_rx (gnt_rx)
  );

  always_comb begin
    cfg_adr = ADR_TX_IRQ;
    cfg_wdt = 32'(TX_LVL);
    case (idx_q)
      3'd0: begin cfg_adr = ADR_TX_BDR; cfg_wdt = 32'(TX_BDR - 1); end
      3'd1: begin cfg_adr = ADR_RX_BDR; cfg_wdt = 32'(RX_BDR - 1); end
      3'd2: begin cfg_adr = ADR_RX_SMP; cfg_wdt = 32'(RX_SMP - 1); end
      3'd3: begin cfg_adr = ADR_RX_IRQ; cfg_wdt = 32'(RX_LVL);     end
      default: ;
    endcase
  end

  // request fields are registered, so every access spends one cycle setting up vld
  always_comb begin
    state_d  = state_q;
    post_rsp = cfg_done ? HOLD : ((idx_q == 3'd4) ? IDLE : CFG);
    load_cfg = 1'b0;
    load_tx  = 1'b0;
    load_rx  = 1'b0;
    case (state_q)
      CFG, TXW, RXR: begin
        load_cfg = (state_q == CFG) && !vld_q;
        if (hs) state_d = (DLY == 0) ? post_rsp : RSP;
      end
      IDLE: begin
        load_rx = gnt_rx;
        load_tx = gnt_tx;
        if (gnt_rx)      state_d = RXR;
        else if (gnt_tx) state_d = TXW;
      end
      RSP:     if (dly_q == 8'd0) state_d = post_rsp;
      HOLD:    if (hold_q == 8'd0) state_d = IDLE;
      default: state_d = CFG;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= CFG;
      idx_q    <= 3'd0;
      dly_q    <= 8'd0;
      hold_q   <= 8'd0;
      vld_q    <= 1'b0;
      wen_q    <= 1'b0;
      adr_q    <= '0;
      wdt_q    <= '0;
      rx_vld   <= 1'b0;
      rx_dat   <= '0;
      cfg_done <= 1'b0;
    end else begin
      state_q <= state_d;
      if (load_cfg) begin
        vld_q <= 1'b1;
        wen_q <= 1'b1;
        adr_q <= cfg_adr;
        wdt_q <= cfg_wdt;
      end else if (load_tx) begin
        vld_q <= 1'b1;
        wen_q <= 1'b1;
        adr_q <= ADR_TX_DAT;
        wdt_q <= 32'(tx_dat);
      end else if (load_rx) begin
        vld_q <= 1'b1;
        wen_q <= 1'b0;
        adr_q <= ADR_RX_DAT;
      end else if (hs) begin
        vld_q <= 1'b0;
      end

      if (hs) dly_q <= DLY_M1;
      else if (state_q == RSP && dly_q != 8'd0) dly_q <= dly_q - 8'd1;

      if (rsp && !cfg_done) begin
        idx_q <= idx_q + 3'd1;
        if (idx_q == 3'd4) cfg_done <= 1'b1;
      end

      // holdoff lets the registered IRQ lines catch up with the access just done
      if (rsp && cfg_done) hold_q <= HLD_W;
      else if (state_q == HOLD && hold_q != 8'd0) hold_q <= hold_q - 8'd1;

      if (rsp && !wen_q) begin
        rx_dat <= tcb.rdt[UDW-1:0];
        rx_vld <= 1'b1;
      end else if (rx_vld && rx_rdy) begin
        rx_vld <= 1'b0;
      end
    end
  end

`ifdef TCB_UART_MGR_ERR_EN
  always_ff @(posedge clk) begin
    if (rst) err <= 1'b0;
    else if (rsp && tcb.sts != '0) err <= 1'b1;
  end
`else
  assign err = 1'b0;
`endif

endmodule

// File: doc/tcb_uart_mgr.md
# tcb_uart_mgr

TCB manager that owns one TCB UART peripheral. It connects to the UART's CRW TCB port and its interrupt lines. After reset it writes the baudrate, sample and IRQ-level registers. It then moves bytes from a TX valid/ready stream into the TX FIFO and from the RX FIFO into an RX valid/ready stream, arbitrating TX and RX accesses round-robin.

## Interface
- `UDW`, 8: UART data width
- `TX_BDR`, 4: TX baudrate divider; register value is `TX_BDR-1`
- `RX_BDR`, 4: RX baudrate divider; register value is `RX_BDR-1`
- `RX_SMP`, 2: RX sample point; register value is `RX_SMP-1`
- `TX_LVL`, 1: TX IRQ level
- `RX_LVL`, 0: RX IRQ level; 0 means `irq_rx` is high whenever the RX FIFO is non-empty
- `HLD`, 2: holdoff cycles after each data access before the IRQ lines are re-sampled

Ports. One clock; reset is synchronous and active-high.
- `clk`  in  1  clock
- `rst`  in  1  synchronous reset, active-high
- `tcb`  `tcb_if` manager modport  —  to UART; `DLY` taken from `tcb.PHY.DLY`
- `tx_vld`  in  1  TX byte valid
- `tx_rdy`  out  1  TX byte accepted
- `tx_dat`  in  `UDW`  TX byte; held stable while `tx_vld`
- `rx_vld`  out  1  RX byte valid
- `rx_rdy`  in  1  RX byte consumed
- `rx_dat`  out  `UDW`  RX byte
- `irq_tx`  in  1  UART TX FIFO load below limit (space available)
- `irq_rx`  in  1  UART RX FIFO load above limit
- `cfg_done`  out  1  configuration complete
- `err`  out  1  sticky TCB error status

## Operation
- **Reset values:** `tcb.vld`=0, `tx_rdy`=0, `rx_vld`=0, `rx_dat`=0, `cfg_done`=0, `err`=0. The FSM resets to `CFG` with index 0.
- **Outstanding transfers:** at most one. Request fields are held stable from `vld` until `vld&&rdy`. The response is sampled `DLY` cycles after the handshake.
- **CFG:** five 32-bit writes in this order:
  - 0x08 ← `TX_BDR-1`
  - 0x28 ← `RX_BDR-1`
  - 0x2C ← `RX_SMP-1`
  - 0x30 ← `RX_LVL`
  - 0x10 ← `TX_LVL`
  - Each write waits for its response before the next is issued.
  - After the fifth response, `cfg_done`=1 and the FSM enters `IDLE`. `cfg_done` stays 1 until reset.
- **IDLE eligibility:**
  - TX is eligible when `tx_vld && irq_tx && hold==0`.
  - RX is eligible when `irq_rx && !rx_vld && hold==0`.
  - If both are eligible, the opposite of the last-served side wins. The last-served flag resets to TX, so RX wins the first tie.
- **TXW:** write 0x00 with `wdt={'0,tx_dat}`, byte enables all 1. `tx_rdy`=1 only in the handshake cycle. The FSM then goes to `RSP`.
- **RXR:** read 0x20, then `RSP`. `rx_dat ← rdt[UDW-1:0]` is captured in the response cycle, and `rx_vld` rises the next cycle. `rx_vld` holds until `rx_vld&&rx_rdy`.
- **RSP → HOLD:** `hold` is loaded with `HLD` and counts down to 0, then the FSM returns to `IDLE`. This prevents acting on stale registered IRQs (no reads of an empty FIFO, no writes to a full one).
- **Reset mid-operation:** any pending transfer is abandoned, the RX buffer is cleared, and the configuration sequence restarts.

## Timing
- Write handshake with `rdy` tied high occurs in the cycle after `vld` rises. Config completes no earlier than 5·(2+`DLY`) cycles after reset release.
- TX byte throughput is at most 1 per (2+`DLY`+`HLD`) cycles.
- RX latency, from `irq_rx` sampled high in `IDLE` to `rx_vld`: 2+`DLY` cycles with `rdy` high.
- A `tx_vld` drop before the handshake is a protocol violation; the behaviour is not defined.

## Configuration
- `TCB_UART_MGR_ERR_EN` defined: a nonzero response status on any transfer sets `err`, which is sticky until reset. Operation continues unchanged.
- Undefined: `err` is tied to 0 and status is ignored.

## Structure
- Shared package `tcb_uart_pkg`: register address constants (0x00, 0x08, 0x10, 0x20, 0x28, 0x2C, 0x30) and the FSM state enum {`CFG`, `IDLE`, `TXW`, `RXR`, `RSP`, `HOLD`}.
- One sub-module, `tcb_uart_mgr_arb`: 2-way round-robin arbiter with last-served flag.

## Test plan
- **Config sequence:** reset released; capture TCB writes → exactly 0x08=3, 0x28=3, 0x2C=1, 0x30=0, 0x10=1 in order. `cfg_done` rises after the fifth response.
- **Loopback:** connect to `tcb_crw_uart` with TXD→RXD looped; stream "Hello, World!" (13 bytes) into TX with `rx_rdy`=1 → RX stream delivers the identical 13 bytes in order, with no reads of 0x20 while the RX FIFO is empty.
- **Tie:** force `irq_tx`=`irq_rx`=1 with `tx_vld`=1 in `IDLE` → accesses alternate RX, TX, RX, TX.
- **RX backpressure:** `rx_rdy`=0 with `irq_rx`=1 → exactly one read of 0x20 is issued, `rx_vld` holds with stable `rx_dat`, and no further RX reads occur until `rx_rdy`=1.
- **Error status:** force `sts`≠0 on the third config write → with `TCB_UART_MGR_ERR_EN`, `err`=1 and stays 1; without it, `err`=0. Config completes in both builds.
- **Reset mid-transfer:** assert `rst` while a TX write is pending → next cycle all outputs are at reset values, and the config sequence restarts at 0x08.
